// File: rtl/pipe_tag_ctrl_if.sv
// Request/response bundle between tag lookup clients and pipe_tag_ctrl.
// The master modport is the client side; the slave modport is the controller.
interface pipe_tag_ctrl_if #(
  parameter int TAG_WIDTH   = 22,
  parameter int INDEX_WIDTH = 4
);
  logic                   lk_valid;
  logic                   lk_ready;
  logic [INDEX_WIDTH-1:0] lk_index;
  logic [TAG_WIDTH-1:0]   lk_tag;

  logic                   rsp_valid;
  logic                   rsp_hit;
  logic [INDEX_WIDTH-1:0] rsp_index;

  logic                   fill_valid;
  logic                   fill_ready;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;

  logic                   inv_valid;
  logic                   inv_ready;
  logic [INDEX_WIDTH-1:0] inv_index;

  logic                   flush;
  logic                   init_done;

  modport master (
    output lk_valid, lk_index, lk_tag,
    output fill_valid, fill_index, fill_tag,
    output inv_valid, inv_index,
    output flush,
    input  lk_ready, fill_ready, inv_ready,
    input  rsp_valid, rsp_hit, rsp_index,
    input  init_done
  );

  modport slave (
    input  lk_valid, lk_index, lk_tag,
    input  fill_valid, fill_index, fill_tag,
    input  inv_valid, inv_index,
    input  flush,
    output lk_ready, fill_ready, inv_ready,
    output rsp_valid, rsp_hit, rsp_index,
    output init_done
  );
endinterface

// File: rtl/pipe_tag_ctrl.sv
// Controller for a 1W/1R pipelined tag SRAM with no reset of its own.
// Sweeps the array to invalid after reset and on flush, arbitrates the
// write port between invalidate and fill (inv first, with a fairness
// streak so fills are not starved), and returns lookup hit/miss one
// cycle after acceptance, forwarding a same-cycle write to the same set.
module pipe_tag_ctrl #(
  parameter int TAG_WIDTH   = 22,
  parameter int INDEX_WIDTH = 4,
  parameter int STREAK_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_tag_ctrl_if.slave         bus,
  output logic                   sram_csb0,
  output logic [INDEX_WIDTH-1:0] sram_addr0,
  output logic [TAG_WIDTH:0]     sram_din0,
  output logic                   sram_csb1,
  output logic [INDEX_WIDTH-1:0] sram_addr1,
  input  logic [TAG_WIDTH:0]     sram_dout1
);

  localparam int DEPTH    = 1 << INDEX_WIDTH;
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(DEPTH - 1);
  localparam logic [STREAK_W-1:0]    STREAK_LIM = STREAK_W'(STREAK_MAX);

  typedef enum logic [1:0] {
    START = 2'd0,
    SWEEP = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [INDEX_WIDTH-1:0] sweep_cnt;
  logic [INDEX_WIDTH-1:0] sweep_cnt_nxt;
  logic [STREAK_W-1:0]    streak;
  logic [STREAK_W-1:0]    streak_nxt;
  logic                   fill_grant;
  logic                   inv_grant;

  // Acceptance-cycle (p0) lookup controls
  logic                   lk_fire_p0;
  logic                   fwd_sel_p0;

  // Response-cycle (p1) registers
  logic                   vld_p1;
  logic                   fwd_sel_p1;
  logic [TAG_WIDTH:0]     fwd_word_p1;
  logic [TAG_WIDTH-1:0]   tag_p1;
  logic [INDEX_WIDTH-1:0] idx_p1;
  logic [TAG_WIDTH:0]     word_p1;

  // A stored word hits when it is valid and its tag field matches.
  function automatic logic tag_hit(input logic [TAG_WIDTH:0]   word,
                                   input logic [TAG_WIDTH-1:0] tag);
    return word[TAG_WIDTH] && (word[TAG_WIDTH-1:0] == tag);
  endfunction

  // Next state, write-port arbitration and SRAM port drive.
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    streak_nxt    = streak;
    bus.lk_ready  = 1'b0;
    fill_grant    = 1'b0;
    inv_grant     = 1'b0;
    sram_csb0     = 1'b1;
    sram_addr0    = '0;
    sram_din0     = '0;
    sram_csb1     = 1'b1;
    sram_addr1    = '0;
    unique case (state)
      START: begin
        state_nxt     = SWEEP;
        sweep_cnt_nxt = '0;
      end
      SWEEP: begin
        sram_csb0     = 1'b0;
        sram_addr0    = sweep_cnt;
        sweep_cnt_nxt = sweep_cnt + INDEX_WIDTH'(1);
        if (sweep_cnt == LAST_IDX) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.lk_ready = 1'b1;
        if (bus.lk_valid) begin
          sram_csb1  = 1'b0;
          sram_addr1 = bus.lk_index;
        end
        if (bus.flush) begin
          // Flush owns this cycle: no writes, restart the sweep.
          state_nxt     = SWEEP;
          sweep_cnt_nxt = '0;
        end else begin
          fill_grant = bus.fill_valid && (!bus.inv_valid || (streak == STREAK_LIM));
          inv_grant  = bus.inv_valid && !fill_grant;
          if (fill_grant) begin
            sram_csb0  = 1'b0;
            sram_addr0 = bus.fill_index;
            sram_din0  = {1'b1, bus.fill_tag};
          end else if (inv_grant) begin
            sram_csb0  = 1'b0;
            sram_addr0 = bus.inv_index;
          end
          if (fill_grant) begin
            streak_nxt = '0;
          end else if (inv_grant && bus.fill_valid) begin
            streak_nxt = streak + STREAK_W'(1);
          end
        end
      end
      default: begin
        state_nxt = START;
      end
    endcase
    // A fill that stops waiting forfeits its accumulated claim.
    if (!bus.fill_valid) begin
      streak_nxt = '0;
    end
  end

  assign bus.fill_ready = fill_grant;
  assign bus.inv_ready  = inv_grant;
  assign bus.init_done  = (state == RUN);

  assign lk_fire_p0 = (state == RUN) && bus.lk_valid;
  // The array only reflects this cycle's write one edge later, so the
  // lookup must take the write word instead of the SRAM output.
  assign fwd_sel_p0 = !sram_csb0 && (sram_addr0 == bus.lk_index);

  // Control state: FSM, sweep counter, fairness streak, response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      sweep_cnt <= '0;
      streak    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      streak    <= streak_nxt;
      vld_p1    <= lk_fire_p0;
    end
  end

  // ---- p0 -> p1: capture lookup operands and bypass word ----
  always_ff @(posedge clk) begin
    if (lk_fire_p0) begin
      tag_p1      <= bus.lk_tag;
      idx_p1      <= bus.lk_index;
      fwd_sel_p1  <= fwd_sel_p0;
      fwd_word_p1 <= sram_din0;
    end
  end

  assign word_p1       = fwd_sel_p1 ? fwd_word_p1 : sram_dout1;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_hit   = vld_p1 && tag_hit(word_p1, tag_p1);
  assign bus.rsp_index = vld_p1 ? idx_p1 : '0;

endmodule
